// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
// Define MEM_ARB_FIXED_PRIO_EN to build the fixed-priority variant.
package mem_arb_pkg;

    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned RD_LATENCY = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat_w;
    } mem_cmd_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way one-hot grant picker: round-robin on the last winner by default,
// fixed priority (req0 first, no last input) when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2
    import mem_arb_pkg::*;
(
`ifndef MEM_ARB_FIXED_PRIO_EN
    input  req_id_t    last,
`endif
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant[0] = valid[0];
        grant[1] = valid[1] & ~valid[0];
    end
`else
    // On a conflict the requester that did not win last time goes first.
    always_comb begin
        grant[0] = valid[0] & (~valid[1] | last);
        grant[1] = valid[1] & (~valid[0] | ~last);
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between two requesters; reads return two cycles after
// acceptance. MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_adr,
    input  logic [DATA_W-1:0] req0_dat_w,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_adr,
    input  logic [DATA_W-1:0] req1_dat_w,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_dat_r,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_dat_r,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_dat_w,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dat_r
);
    import mem_arb_pkg::*;

    logic [1:0] valid;
    logic [1:0] grant;
    req_id_t    cmd_owner;
    req_id_t    rsp_owner;
    logic       cmd_rd;
    logic       rsp_rd;

    assign valid = {req1_valid, req0_valid};

`ifdef MEM_ARB_FIXED_PRIO_EN
    rr_pick2 u_pick (
        .valid (valid),
        .grant (grant)
    );
`else
    req_id_t last;

    rr_pick2 u_pick (
        .last  (last),
        .valid (valid),
        .grant (grant)
    );
`endif

    assign req0_ready = grant[0] & ~rst;
    assign req1_ready = grant[1] & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_adr   <= '0;
            mem_dat_w <= '0;
            mem_we    <= 1'b0;
            cmd_rd    <= 1'b0;
            cmd_owner <= 1'b0;
            rsp_rd    <= 1'b0;
            rsp_owner <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last      <= 1'b1;
`endif
        end else begin
            if (grant[1]) begin
                mem_adr   <= req1_adr;
                mem_dat_w <= req1_dat_w;
                mem_we    <= req1_we;
                cmd_rd    <= ~req1_we;
                cmd_owner <= 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
                last      <= 1'b1;
`endif
            end else if (grant[0]) begin
                mem_adr   <= req0_adr;
                mem_dat_w <= req0_dat_w;
                mem_we    <= req0_we;
                cmd_rd    <= ~req0_we;
                cmd_owner <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                last      <= 1'b0;
`endif
            end else begin
                mem_we <= 1'b0;
                cmd_rd <= 1'b0;
            end
            rsp_rd    <= cmd_rd;
            rsp_owner <= cmd_owner;
        end
    end

    // Gating with rst also drops a response that falls due in the reset cycle itself.
    assign rsp0_valid = rsp_rd & ~rsp_owner & ~rst;
    assign rsp1_valid = rsp_rd & rsp_owner & ~rst;
    assign rsp0_dat_r = rsp0_valid ? mem_dat_r : '0;
    assign rsp1_dat_r = rsp1_valid ? mem_dat_r : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a behavioural memory and model.
module tb_mem_port_arbiter;

    localparam int AW = mem_arb_pkg::ADDR_W;
    localparam int DW = mem_arb_pkg::DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_adr;
    logic [DW-1:0] req0_dat_w;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_adr;
    logic [DW-1:0] req1_dat_w;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_dat_r, rsp1_dat_r;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_dat_w;
    logic          mem_we;
    logic [DW-1:0] mem_dat_r;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_adr   (req0_adr),
        .req0_dat_w (req0_dat_w),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_adr   (req1_adr),
        .req1_dat_w (req1_dat_w),
        .rsp0_valid (rsp0_valid),
        .rsp0_dat_r (rsp0_dat_r),
        .rsp1_valid (rsp1_valid),
        .rsp1_dat_r (rsp1_dat_r),
        .mem_adr    (mem_adr),
        .mem_dat_w  (mem_dat_w),
        .mem_we     (mem_we),
        .mem_dat_r  (mem_dat_r)
    );

    // Single-port memory with registered read address.
    logic [DW-1:0] ram [16];
    logic [AW-1:0] ram_adr_q;
    always @(posedge clk) begin
        if (mem_we) ram[mem_adr] <= mem_dat_w;
        ram_adr_q <= mem_adr;
    end
    assign mem_dat_r = ram[ram_adr_q];

    // Reference model: acceptance order defines memory contents, reads resolve at acceptance.
    typedef struct {
        int            due;
        bit            owner;
        logic [DW-1:0] data;
    } rsp_t;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    bit            last_m = 1'b1;
    logic [DW-1:0] mem_m [16];
    rsp_t          pend[$];
    bit            mem_known = 1'b0;
    logic          exp_we;
    logic [AW-1:0] exp_adr;
    logic [DW-1:0] exp_dw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit r,
                        input bit v0, input bit w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0,
                        input bit v1, input bit w1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1);
        int            g;
        bit            e0v, e1v;
        logic [DW-1:0] e0d, e1d;
        bit            sw;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        @(negedge clk);
        rst = r;
        req0_valid = v0; req0_we = w0; req0_adr = a0; req0_dat_w = d0;
        req1_valid = v1; req1_we = w1; req1_adr = a1; req1_dat_w = d1;
        #1;
        g = -1;
        if (!r) begin
            if (v0 && v1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = (last_m == 1'b0) ? 1 : 0;
`endif
            end else if (v0) begin
                g = 0;
            end else if (v1) begin
                g = 1;
            end
        end
        check("req0_ready", {31'b0, req0_ready}, {31'b0, g == 0});
        check("req1_ready", {31'b0, req1_ready}, {31'b0, g == 1});

        e0v = 0; e1v = 0; e0d = '0; e1d = '0;
        while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (!r) begin
                if (pend[0].owner) begin e1v = 1; e1d = pend[0].data; end
                else begin e0v = 1; e0d = pend[0].data; end
            end
            void'(pend.pop_front());
        end
        check("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, e0v});
        check("rsp0_dat_r", {24'b0, rsp0_dat_r}, {24'b0, e0d});
        check("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, e1v});
        check("rsp1_dat_r", {24'b0, rsp1_dat_r}, {24'b0, e1d});
        if (mem_known) begin
            check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
            check("mem_adr", {28'b0, mem_adr}, {28'b0, exp_adr});
            check("mem_dat_w", {24'b0, mem_dat_w}, {24'b0, exp_dw});
        end

        if (r) begin
            pend.delete();
            last_m = 1'b1;
            mem_known = 1'b1;
            exp_we = 1'b0; exp_adr = '0; exp_dw = '0;
        end else if (g >= 0) begin
            sw = (g == 1) ? w1 : w0;
            sa = (g == 1) ? a1 : a0;
            sd = (g == 1) ? d1 : d0;
            if (sw) mem_m[sa] = sd;
            else pend.push_back('{due: cyc + 2, owner: (g == 1), data: mem_m[sa]});
            last_m = (g == 1);
            exp_we = sw; exp_adr = sa; exp_dw = sd;
        end else begin
            exp_we = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i] = '0;
            mem_m[i] = '0;
        end
        ram_adr_q = '0;
        rst = 1'b1;
        req0_valid = 0; req0_we = 0; req0_adr = '0; req0_dat_w = '0;
        req1_valid = 0; req1_we = 0; req1_adr = '0; req1_dat_w = '0;

        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        idle(3);

        // First conflict: both write, req0 must win; then preload 0x11/0x22.
        step(0, 1, 1, 4'd1, 8'h11, 1, 1, 4'd2, 8'h22);
        step(0, 0, 0, '0, '0, 1, 1, 4'd2, 8'h22);
        idle(2);

        // Both read continuously: grants alternate, responses alternate.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 4'd1, '0, 1, 0, 4'd2, '0);
        idle(3);

        // Write then read-after-write from the other requester.
        step(0, 1, 1, 4'd3, 8'hA5, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0, 1, 0, 4'd3, '0);
        idle(3);

        // Read in flight is discarded by reset.
        step(0, 0, 0, '0, '0, 1, 0, 4'd7, '0);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        idle(3);

        // Back-to-back writes from req1 alone, then readback.
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0, 1, 1, AW'(i), DW'(i + 1));
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0, 1, 0, AW'(i), '0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 AW'($urandom_range(0, 7)), DW'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 AW'($urandom_range(0, 7)), DW'($urandom));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port 16x8 register-file memory (registered read address, one read/write port) between two independent masters. Each cycle it grants at most one request, registers the winning command onto the memory port, and routes the returned read data back to the owning requester two cycles after acceptance. It sits directly in front of the memory, and the memory's `adr`/`dat_w`/`we`/`dat_r` connect only to this block.

## Interface
- `ADDR_W`, default 4: memory address width (16 entries).
- `DATA_W`, default 8: memory data width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester N has a command.
- `req0_ready` / `req1_ready`  out  1  command accepted this cycle (combinational grant).
- `req0_we` / `req1_we`  in  1  1 = write, 0 = read.
- `req0_adr` / `req1_adr`  in  ADDR_W  command address.
- `req0_dat_w` / `req1_dat_w`  in  DATA_W  write data.
- `rsp0_valid` / `rsp1_valid`  out  1  read data valid for requester N (one-cycle pulse).
- `rsp0_dat_r` / `rsp1_dat_r`  out  DATA_W  read data; 0 when the matching `rspN_valid` is low.
- `mem_adr`  out  ADDR_W  registered address to memory.
- `mem_dat_w`  out  DATA_W  registered write data.
- `mem_we`  out  1  registered write enable.
- `mem_dat_r`  in  DATA_W  memory read data (valid the cycle after `mem_adr` is presented).

## Operation
- Handshake: a command transfers when `reqN_valid && reqN_ready`. `reqN_ready` is never asserted without `reqN_valid`. At most one ready is high per cycle.
- Arbitration (round-robin): a 1-bit `last` pointer records the most recent winner. If only one requester is valid, it wins. If both are valid, the requester not equal to `last` wins. `last` updates only on an accepted transfer.
- Command stage: on acceptance, `mem_adr`, `mem_dat_w`, `mem_we` and a 1-bit owner tag plus an `is_read` flag are registered. With no acceptance, `mem_we` registers 0, and `mem_adr`/`mem_dat_w` hold their values.
- Response stage: the registered `is_read` and owner tag advance one further stage. `rspN_valid` = that stage is a read owned by N; `rspN_dat_r` = `mem_dat_r` gated by `rspN_valid`.
- Writes produce no response.
- Throughput is one command per cycle, with no bubbles between back-to-back commands from either requester.
- Ordering: memory operations execute in acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- Reset: `req*_ready`=0 during reset. `mem_adr`=0, `mem_dat_w`=0, `mem_we`=0, `rsp*_valid`=0, `rsp*_dat_r`=0, and `last`=1, so req0 wins the first conflict. In-flight reads are discarded with no response. Memory contents are untouched.

## Timing
- Cycle N: the request is accepted (combinational ready).
- Rising edge ending N: the command is registered, and `mem_*` is valid throughout N+1.
- Rising edge ending N+1: a write commits, or the memory latches the read address.
- Cycle N+2: `rspN_valid`=1 and `rspN_dat_r` holds the data.
- Read latency is therefore 2 cycles from acceptance. Write-commit latency is 1 cycle.
- `rst` asserted in any cycle: the following cycle shows reset values. A response due during or right after reset is suppressed.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: fixed priority. req0 always wins a conflict, `last` is not implemented, and req1 can starve.
- Undefined (default): round-robin as described above.

## Structure
- Package `mem_arb_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults;
  - `req_id_t` (1-bit owner tag);
  - a `mem_cmd_t` struct (`we`, `adr`, `dat_w`);
  - `RD_LATENCY` = 2.
- One sub-module, `rr_pick2`: a 2-way grant picker taking valids and `last` and returning a one-hot grant. It takes a compile-time fixed-priority variant under the macro.
- Pipeline registers and response routing live in `mem_port_arbiter`.

## Test plan
- Reset, then idle: all outputs 0. First conflict with both valid → req0 granted.
- req0 writes 0xA5 to addr 3 at cycle N, then req1 reads addr 3 at N+1 → `rsp1_valid`=1 with 0xA5 at N+3, and `rsp0_valid` stays 0.
- Both requesters hold valid reads for 6 cycles (req0 addr 1, req1 addr 2, preloaded 0x11/0x22) → grants alternate 0,1,0,1,0,1 and responses alternate 0x11/0x22 with 2-cycle latency.
- With `MEM_ARB_FIXED_PRIO_EN`, the same stimulus → req0 granted all 6 cycles and `req1_ready` stays 0.
- req1 reads addr 7 at cycle N, and `rst` is asserted at N+1 → no `rsp1_valid` pulse, and outputs reset at N+2.
- Only req1 valid for 3 consecutive writes (addr 0,1,2; data 0x01,0x02,0x03) → accepted on 3 consecutive cycles, `mem_we`=1 for 3 cycles, and readback returns the same values.
